// File: rtl/instr_prefetch_pkg.sv
// Shared definitions for the instruction prefetch stage: fetch FSM states and
// instruction/PC constants.
package instr_prefetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDrop
    } fetch_state_e;

endpackage

// File: rtl/occ_counter.sv
// FIFO occupancy counter: clear, increment and decrement, saturating at Depth
// and at zero. Clear wins over inc/dec; simultaneous inc and dec cancel.
module occ_counter #(
    parameter int unsigned Depth = 3,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CntW-1:0] count_o,
    output logic            full_o
);

    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !dec_i) begin
            if (count_q != DepthCnt) count_d = count_q + 1'b1;
        end else if (dec_i && !inc_i) begin
            if (count_q != '0) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count_o = count_q;
    assign full_o  = (count_q == DepthCnt);

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch: single-outstanding word fetches into a small FIFO, with
// occupancy-based flow control and redirect flush.
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 3,
    localparam int unsigned CntW    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               fifo_wren,
    output logic [INSTR_W-1:0] fifo_data,
    output logic               fifo_wrptr_clr,
    output logic               fifo_rdptr_clr,
    input  logic               pop,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               full,
    output logic [CntW-1:0]    count
);

    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    fetch_state_e    state_q;
    logic [31:0]     pc_q;
    logic [31:0]     pc_next;
    logic            pop_eff;
    logic            ack_take;
    logic [CntW-1:0] count_after_pop;
    logic            space_after_pop;
    logic            space_after_ack;
    logic            unused_pc_lsb;

    assign pc_next         = pc_q + PC_STEP;
    assign pop_eff         = pop && (count != '0);
    assign ack_take        = (state_q == StReq) && imem_ack && !redirect;
    assign count_after_pop = count - CntW'(pop_eff);
    assign space_after_pop = count_after_pop < DepthCnt;
    // The accepted word reserves one more entry on top of the post-pop count.
    assign space_after_ack = count_after_pop < (DepthCnt - 1'b1);
    assign unused_pc_lsb   = ^redirect_pc[1:0];

    occ_counter #(
        .Depth (DEPTH)
    ) u_occ_counter (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (redirect),
        .inc_i   (ack_take),
        .dec_i   (pop_eff),
        .count_o (count),
        .full_o  (full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            pc_q           <= RESET_PC;
            imem_req       <= 1'b0;
            imem_addr      <= RESET_PC;
            fifo_wren      <= 1'b0;
            fifo_data      <= '0;
            fifo_wrptr_clr <= 1'b0;
            fifo_rdptr_clr <= 1'b0;
        end else begin
            fifo_wren      <= 1'b0;
            fifo_wrptr_clr <= 1'b0;
            fifo_rdptr_clr <= 1'b0;
            if (redirect) begin
                pc_q           <= {redirect_pc[31:2], 2'b00};
                fifo_wrptr_clr <= 1'b1;
                fifo_rdptr_clr <= 1'b1;
                // A request still waiting on memory must complete before refetching.
                if ((state_q == StReq || state_q == StDrop) && !imem_ack) begin
                    state_q <= StDrop;
                end else begin
                    state_q  <= StIdle;
                    imem_req <= 1'b0;
                end
            end else begin
                case (state_q)
                    StIdle: begin
                        if (space_after_pop) begin
                            state_q   <= StReq;
                            imem_req  <= 1'b1;
                            imem_addr <= pc_q;
                        end
                    end
                    StReq: begin
                        if (imem_ack) begin
                            fifo_wren <= 1'b1;
                            fifo_data <= imem_rdata;
                            pc_q      <= pc_next;
                            imem_addr <= pc_next;
                            if (!space_after_ack) begin
                                state_q  <= StIdle;
                                imem_req <= 1'b0;
                            end
                        end
                    end
                    StDrop: begin
                        if (imem_ack) begin
                            state_q  <= StIdle;
                            imem_req <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= StIdle;
                        imem_req <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: memory responder plus driver issue stimulus and queue
// expected FIFO writes; an independent negedge monitor checks every cycle.
module tb_instr_prefetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        fifo_wren;
    logic [31:0] fifo_data;
    logic        fifo_wrptr_clr;
    logic        fifo_rdptr_clr;
    logic        pop = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        full;
    logic [1:0]  count;

    instr_prefetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .fifo_wren      (fifo_wren),
        .fifo_data      (fifo_data),
        .fifo_wrptr_clr (fifo_wrptr_clr),
        .fifo_rdptr_clr (fifo_rdptr_clr),
        .pop            (pop),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .full           (full),
        .count          (count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          occ = 0;
    int          wren_total = 0;
    int          idle_run = 0;
    logic        rst_s = 1'b1;
    logic        redirect_s = 1'b0;
    logic        pop_s = 1'b0;
    logic        ack_s = 1'b0;
    logic        prev_req = 1'b0;
    logic [31:0] prev_addr = '0;

    // Responder/model state, owned by the driver.
    logic        in_req = 1'b0;
    logic        stale = 1'b0;
    int          wait_cnt = 0;
    logic [31:0] model_pc = RESET_PC;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        rst_s      <= rst;
        redirect_s <= redirect;
        pop_s      <= pop;
        ack_s      <= imem_ack;
    end

    // Monitor
    always @(negedge clk) begin
        if (fifo_wren) begin
            wren_total++;
            chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) chk("fifo_data", fifo_data, exp_q.pop_front());
        end
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        if (rst_s) begin
            occ = 0;
            chk("rst_imem_req", 32'(imem_req), 32'd0);
            chk("rst_imem_addr", imem_addr, RESET_PC);
            chk("rst_fifo_wren", 32'(fifo_wren), 32'd0);
            chk("rst_fifo_data", fifo_data, 32'd0);
        end else if (redirect_s) begin
            occ = 0;
        end else begin
            occ = occ - int'(pop_s) + int'(fifo_wren);
        end
        chk("wrptr_clr", 32'(fifo_wrptr_clr), 32'(redirect_s && !rst_s));
        chk("rdptr_clr", 32'(fifo_rdptr_clr), 32'(redirect_s && !rst_s));
        chk("count", 32'(count), 32'(occ));
        chk("full", 32'(full), 32'(occ == DEPTH));
        chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
        if (occ == DEPTH) chk("req_when_full", 32'(imem_req), 32'd0);
        if (!rst_s && prev_req && !ack_s) begin
            chk("req_held", 32'(imem_req), 32'd1);
            chk("addr_stable", imem_addr, prev_addr);
        end

        if (rst_s || redirect_s) idle_run = 0;
        else if (!imem_req && occ < DEPTH) idle_run++;
        else idle_run = 0;
        chk("fetch_stall", 32'(idle_run > 1), 32'd0);
        if (idle_run > 1) idle_run = 0;

        prev_req  = imem_req;
        prev_addr = imem_addr;
    end

    // lat < 0 draws a random latency per request; stray drives ack with no request.
    task automatic step(input int lat, input bit want_pop, input bit want_redir,
                        input logic [31:0] rpc, input bit want_rst, input bit stray);
        @(negedge clk);
        #1;
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (!imem_req) begin
            in_req = 1'b0;
            if (stray) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
            end
        end else begin
            if (!in_req) begin
                in_req = 1'b1;
                if (lat < 0) wait_cnt = int'($urandom_range(0, 3));
                else wait_cnt = lat;
            end
            if (wait_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                in_req     = 1'b0;
            end else begin
                wait_cnt--;
            end
        end
        pop         = want_pop && (occ > 0);
        redirect    = want_redir;
        redirect_pc = rpc;
        rst         = want_rst;
        if (want_rst) begin
            stale    = 1'b0;
            in_req   = 1'b0;
            model_pc = RESET_PC;
        end else begin
            if (imem_req && imem_ack) begin
                if (!stale && !want_redir) begin
                    exp_q.push_back(mem_word(model_pc));
                    model_pc = model_pc + 32'd4;
                end
                stale = 1'b0;
            end else if (imem_req && want_redir) begin
                stale = 1'b1;
            end
            if (want_redir) model_pc = {rpc[31:2], 2'b00};
        end
    endtask

    initial begin
        int w0;
        int r;
        // Reset, zero-wait memory, no pops: fill to full.
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0);
        chk("t1_full", 32'(full), 32'd1);
        chk("t1_req_idle", 32'(imem_req), 32'd0);
        chk("t1_wren_total", 32'(wren_total), 32'd3);

        // One pop from full: exactly one refill.
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0);
        chk("t2_count", 32'(count), 32'd3);
        chk("t2_wren_total", 32'(wren_total), 32'd4);

        // Pop and ack in the same cycle at count 2.
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("t3_count_held", 32'(count), 32'd2);
        chk("t3_req_next", 32'(imem_req), 32'd1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0);
        chk("t3_refull", 32'(full), 32'd1);

        // Three-cycle memory latency.
        w0 = wren_total;
        step(3, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(3, 0, 0, 0, 0, 0);
        chk("t4_single_wren", 32'(wren_total - w0), 32'd1);
        chk("t4_count", 32'(count), 32'd3);

        // Redirect while a request is pending.
        step(3, 1, 0, 0, 0, 0);
        step(3, 0, 0, 0, 0, 0);
        step(3, 0, 1, 32'h0000_1003, 0, 0);
        step(3, 0, 0, 0, 0, 0);
        chk("t5_count_zero", 32'(count), 32'd0);
        chk("t5_drop_req_held", 32'(imem_req), 32'd1);
        w0 = wren_total;
        for (int i = 0; i < 30; i++) step(3, 0, 0, 0, 0, 0);
        chk("t5_refill", 32'(wren_total - w0), 32'd3);
        chk("t5_full", 32'(full), 32'd1);

        // Reset mid-request, then a stray ack.
        step(3, 1, 0, 0, 0, 0);
        step(3, 0, 0, 0, 0, 0);
        step(3, 0, 0, 0, 1, 0);
        step(3, 0, 0, 0, 0, 1);
        w0 = wren_total;
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 0);
        chk("t6_refill", 32'(wren_total - w0), 32'd3);
        chk("t6_full", 32'(full), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 99));
            step(-1, 1'($urandom_range(0, 1)), r < 3, $urandom, r == 99,
                 $urandom_range(0, 19) == 0);
        end
        for (int i = 0; i < 20; i++) step(-1, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
